// File: rtl/frog_game_state.sv
// Round-level game flow for the frog game: lives, hit freeze, respawn,
// level win and game over. All timing is counted in video frames.
module frog_game_state #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned WIN_FRAMES  = 30,
  parameter int unsigned WIN_Y       = 32,
  parameter int unsigned MAX_LEVEL   = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Has_Collided,
  input  logic [8:0] i_Frog_Y,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  output logic       o_Freeze,
  output logic       o_Frog_Reset,
  output logic       o_Level_Up,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Game_Over,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    HIT     = 3'd2,
    RESPAWN = 3'd3,
    WIN     = 3'd4,
    OVER    = 3'd5
  } state_t;

  localparam logic [1:0] START_LIVES_C = 2'(START_LIVES);
  localparam logic [7:0] HIT_FRAMES_C  = 8'(HIT_FRAMES);
  localparam logic [7:0] WIN_FRAMES_C  = 8'(WIN_FRAMES);
  localparam logic [8:0] WIN_Y_C       = 9'(WIN_Y);
  localparam logic [3:0] MAX_LEVEL_C   = 4'(MAX_LEVEL);

  state_t     state_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] frame_cnt_inc;

  assign frame_cnt_inc = frame_cnt_q + 8'd1;
  assign o_State       = state_q;

  // Game-flow FSM with registered outputs; pulses default low each cycle.
  // The counter is cleared on every transition, so a tick landing on the
  // entry edge is not counted and exit happens exactly at equality.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      o_Freeze     <= 1'b1;
      o_Frog_Reset <= 1'b0;
      o_Level_Up   <= 1'b0;
      o_Lives      <= START_LIVES_C;
      o_Level      <= 4'd1;
      o_Game_Over  <= 1'b0;
    end else begin
      o_Frog_Reset <= 1'b0;
      o_Level_Up   <= 1'b0;
      unique case (state_q)
        IDLE, OVER: begin
          if (i_Start) begin
            state_q      <= PLAY;
            frame_cnt_q  <= '0;
            o_Lives      <= START_LIVES_C;
            o_Level      <= 4'd1;
            o_Frog_Reset <= 1'b1;
            o_Freeze     <= 1'b0;
            o_Game_Over  <= 1'b0;
          end
        end
        PLAY: begin
          if (i_Has_Collided) begin
            state_q     <= HIT;
            frame_cnt_q <= '0;
            o_Freeze    <= 1'b1;
            if (o_Lives != 2'd0) begin
              o_Lives <= o_Lives - 2'd1;
            end
          end else if (i_Frog_Y < WIN_Y_C) begin
            state_q     <= WIN;
            frame_cnt_q <= '0;
            o_Freeze    <= 1'b1;
            o_Level_Up  <= 1'b1;
            if (o_Level < MAX_LEVEL_C) begin
              o_Level <= o_Level + 4'd1;
            end
          end
        end
        HIT: begin
          if (i_Frame_Tick) begin
            if (frame_cnt_inc == HIT_FRAMES_C) begin
              frame_cnt_q <= '0;
              if (o_Lives == 2'd0) begin
                state_q     <= OVER;
                o_Game_Over <= 1'b1;
              end else begin
                state_q      <= RESPAWN;
                o_Frog_Reset <= 1'b1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_inc;
            end
          end
        end
        WIN: begin
          if (i_Frame_Tick) begin
            if (frame_cnt_inc == WIN_FRAMES_C) begin
              frame_cnt_q  <= '0;
              state_q      <= RESPAWN;
              o_Frog_Reset <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_inc;
            end
          end
        end
        RESPAWN: begin
          if (!i_Has_Collided) begin
            state_q     <= PLAY;
            frame_cnt_q <= '0;
            o_Freeze    <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          frame_cnt_q <= '0;
          o_Freeze    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frog_game_state.sv
// Directed self-checking bench for frog_game_state.
module tb_frog_game_state;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_Has_Collided;
  logic [8:0] i_Frog_Y;
  logic       i_Frame_Tick;
  logic       i_Start;
  logic       o_Freeze;
  logic       o_Frog_Reset;
  logic       o_Level_Up;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Game_Over;
  logic [2:0] o_State;

  int total = 0;
  int bad   = 0;

  frog_game_state #(
    .START_LIVES(3),
    .HIT_FRAMES(60),
    .WIN_FRAMES(30),
    .WIN_Y(32),
    .MAX_LEVEL(9)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Has_Collided(i_Has_Collided),
    .i_Frog_Y(i_Frog_Y),
    .i_Frame_Tick(i_Frame_Tick),
    .i_Start(i_Start),
    .o_Freeze(o_Freeze),
    .o_Frog_Reset(o_Frog_Reset),
    .o_Level_Up(o_Level_Up),
    .o_Lives(o_Lives),
    .o_Level(o_Level),
    .o_Game_Over(o_Game_Over),
    .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // n frame ticks, each followed by one idle cycle
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      i_Frame_Tick = 1'b1;
      step();
      i_Frame_Tick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0; i_Has_Collided = 1'b0; i_Frog_Y = 9'd200;
    i_Frame_Tick = 1'b0; i_Start = 1'b0;
    step(); step();
    total++; if (o_State !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_State); end
    total++; if (o_Freeze !== 1'b1) begin bad++; $display("FAIL reset_freeze got=%b exp=1", o_Freeze); end
    total++; if (o_Lives !== 2'd3) begin bad++; $display("FAIL reset_lives got=%0d exp=3", o_Lives); end
    total++; if (o_Level !== 4'd1) begin bad++; $display("FAIL reset_level got=%0d exp=1", o_Level); end
    total++; if ({o_Frog_Reset, o_Level_Up, o_Game_Over} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {o_Frog_Reset, o_Level_Up, o_Game_Over}); end
    i_Rst_L = 1'b1;
    step(); step();
    total++; if (o_State !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", o_State); end
  endtask

  task automatic test_start();
    i_Start = 1'b1; step(); i_Start = 1'b0;
    total++; if (o_State !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", o_State); end
    total++; if (o_Lives !== 2'd3 || o_Level !== 4'd1) begin bad++; $display("FAIL start_vals lives=%0d level=%0d exp 3/1", o_Lives, o_Level); end
    total++; if (o_Frog_Reset !== 1'b1) begin bad++; $display("FAIL start_frog_reset got=%b exp=1", o_Frog_Reset); end
    total++; if (o_Freeze !== 1'b0) begin bad++; $display("FAIL start_freeze got=%b exp=0", o_Freeze); end
    step();
    total++; if (o_Frog_Reset !== 1'b0) begin bad++; $display("FAIL start_pulse_len got=%b exp=0", o_Frog_Reset); end
  endtask

  task automatic test_hit();
    i_Has_Collided = 1'b1; step();
    total++; if (o_State !== 3'd2 || o_Lives !== 2'd2 || o_Freeze !== 1'b1) begin bad++; $display("FAIL hit_entry state=%0d lives=%0d freeze=%b exp 2/2/1", o_State, o_Lives, o_Freeze); end
    step(); step(); step(); step();
    total++; if (o_Lives !== 2'd2) begin bad++; $display("FAIL hit_held_lives got=%0d exp=2", o_Lives); end
    run_ticks(59);
    total++; if (o_State !== 3'd2) begin bad++; $display("FAIL hit_59_ticks got=%0d exp=2", o_State); end
    i_Frame_Tick = 1'b1; step(); i_Frame_Tick = 1'b0;
    total++; if (o_State !== 3'd3 || o_Frog_Reset !== 1'b1) begin bad++; $display("FAIL hit_exit state=%0d frog_reset=%b exp 3/1", o_State, o_Frog_Reset); end
    step();
    total++; if (o_State !== 3'd3 || o_Frog_Reset !== 1'b0) begin bad++; $display("FAIL respawn_wait state=%0d frog_reset=%b exp 3/0", o_State, o_Frog_Reset); end
    i_Has_Collided = 1'b0; step();
    total++; if (o_State !== 3'd1 || o_Lives !== 2'd2 || o_Freeze !== 1'b0) begin bad++; $display("FAIL respawn_play state=%0d lives=%0d freeze=%b exp 1/2/0", o_State, o_Lives, o_Freeze); end
  endtask

  task automatic test_priority();
    i_Frog_Y = 9'd20; i_Has_Collided = 1'b1; step();
    i_Frog_Y = 9'd200; i_Has_Collided = 1'b0;
    total++; if (o_State !== 3'd2 || o_Lives !== 2'd1) begin bad++; $display("FAIL prio_hit state=%0d lives=%0d exp 2/1", o_State, o_Lives); end
    total++; if (o_Level_Up !== 1'b0 || o_Level !== 4'd1) begin bad++; $display("FAIL prio_no_win level_up=%b level=%0d exp 0/1", o_Level_Up, o_Level); end
    run_ticks(60);
    total++; if (o_State !== 3'd1 || o_Lives !== 2'd1) begin bad++; $display("FAIL prio_back state=%0d lives=%0d exp 1/1", o_State, o_Lives); end
  endtask

  task automatic test_win();
    i_Frog_Y = 9'd31; step(); i_Frog_Y = 9'd32;
    total++; if (o_State !== 3'd4 || o_Level_Up !== 1'b1 || o_Level !== 4'd2) begin bad++; $display("FAIL win_entry state=%0d level_up=%b level=%0d exp 4/1/2", o_State, o_Level_Up, o_Level); end
    step();
    total++; if (o_Level_Up !== 1'b0) begin bad++; $display("FAIL win_pulse_len got=%b exp=0", o_Level_Up); end
    run_ticks(29);
    total++; if (o_State !== 3'd4) begin bad++; $display("FAIL win_29_ticks got=%0d exp=4", o_State); end
    i_Frame_Tick = 1'b1; step(); i_Frame_Tick = 1'b0;
    total++; if (o_State !== 3'd3 || o_Frog_Reset !== 1'b1 || o_Lives !== 2'd1) begin bad++; $display("FAIL win_exit state=%0d frog_reset=%b lives=%0d exp 3/1/1", o_State, o_Frog_Reset, o_Lives); end
    step();
    total++; if (o_State !== 3'd1) begin bad++; $display("FAIL win_play got=%0d exp=1", o_State); end
    step(); step();
    total++; if (o_State !== 3'd1) begin bad++; $display("FAIL y32_no_goal got=%0d exp=1", o_State); end
    i_Frog_Y = 9'd200;
  endtask

  task automatic test_game_over();
    i_Has_Collided = 1'b1; step(); i_Has_Collided = 1'b0;
    total++; if (o_State !== 3'd2 || o_Lives !== 2'd0) begin bad++; $display("FAIL last_hit state=%0d lives=%0d exp 2/0", o_State, o_Lives); end
    run_ticks(60);
    total++; if (o_State !== 3'd5 || o_Game_Over !== 1'b1 || o_Lives !== 2'd0) begin bad++; $display("FAIL over state=%0d game_over=%b lives=%0d exp 5/1/0", o_State, o_Game_Over, o_Lives); end
    total++; if (o_Level !== 4'd2 || o_Freeze !== 1'b1 || o_Frog_Reset !== 1'b0) begin bad++; $display("FAIL over_vals level=%0d freeze=%b frog_reset=%b exp 2/1/0", o_Level, o_Freeze, o_Frog_Reset); end
    i_Start = 1'b1; step(); i_Start = 1'b0;
    total++; if (o_State !== 3'd1 || o_Lives !== 2'd3 || o_Level !== 4'd1 || o_Game_Over !== 1'b0 || o_Frog_Reset !== 1'b1) begin bad++; $display("FAIL restart state=%0d lives=%0d level=%0d game_over=%b frog_reset=%b exp 1/3/1/0/1", o_State, o_Lives, o_Level, o_Game_Over, o_Frog_Reset); end
    step();
  endtask

  task automatic test_level_saturation();
    int exp_level;
    for (int k = 1; k <= 9; k++) begin
      exp_level = (k + 1 > 9) ? 9 : k + 1;
      i_Frog_Y = 9'd20; step(); i_Frog_Y = 9'd200;
      total++; if (o_Level_Up !== 1'b1 || o_Level !== 4'(exp_level)) begin bad++; $display("FAIL sat_win%0d level_up=%b level=%0d exp 1/%0d", k, o_Level_Up, o_Level, exp_level); end
      run_ticks(30);
    end
    total++; if (o_State !== 3'd1 || o_Level !== 4'd9) begin bad++; $display("FAIL sat_end state=%0d level=%0d exp 1/9", o_State, o_Level); end
  endtask

  task automatic test_reset_mid_hit();
    int pulses;
    i_Has_Collided = 1'b1; step(); i_Has_Collided = 1'b0;
    run_ticks(30);
    total++; if (o_State !== 3'd2) begin bad++; $display("FAIL mid_hit got=%0d exp=2", o_State); end
    i_Rst_L = 1'b0; #1;
    total++; if (o_State !== 3'd0 || o_Lives !== 2'd3 || o_Freeze !== 1'b1 || o_Level !== 4'd1) begin bad++; $display("FAIL async_reset state=%0d lives=%0d freeze=%b level=%0d exp 0/3/1/1", o_State, o_Lives, o_Freeze, o_Level); end
    step(); i_Rst_L = 1'b1;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      i_Frame_Tick = (i % 2 == 0);
      step();
      if (o_Frog_Reset !== 1'b0 || o_State !== 3'd0) pulses++;
    end
    i_Frame_Tick = 1'b0;
    total++; if (pulses !== 0) begin bad++; $display("FAIL post_reset_quiet events=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_priority();
    test_win();
    test_game_over();
    test_level_saturation();
    test_reset_mid_hit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
